// File: rtl/rom_arb_pkg.sv
// Shared types and default timing constants for the ROM read arbiter.
package rom_arb_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StIssue,
        StWait,
        StDone
    } rom_arb_state_e;

    localparam int unsigned DEF_READ_LAT    = 3;
    localparam int unsigned DEF_INIT_CYCLES = 100;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational request picker: first requester at or after ptr (wrapping) wins.
module rom_arb_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic                     found
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one fixed-latency ROM among N_REQ requesters after a power-up wait.
// Define ROM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned READ_LAT    = DEF_READ_LAT,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    ready,
    output logic                    rom_rd,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_data
);

    localparam int unsigned PTR_W   = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (INIT_CYCLES > READ_LAT) ? INIT_CYCLES : READ_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    rom_arb_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  win_q, win_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ready_q, ready_d;
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic [N_REQ-1:0]  grant;
    logic              found;
    logic [ADDR_W-1:0] grant_addr;
    logic [PTR_W-1:0]  ptr_sel;

`ifdef ROM_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) win_idx = PTR_W'(i);
        end
        ptr_d = ptr_q;
        if (state_q == StIdle && found) begin
            ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_sel = ptr_q;
`else
    assign ptr_sel = '0;
`endif

    rom_arb_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_sel),
        .grant(grant),
        .found(found)
    );

    always_comb begin
        grant_addr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_addr |= req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant[i]}};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        ack_d      = '0;
        rd_data_d  = rd_data_q;
        ready_d    = ready_q;
        rom_rd_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        case (state_q)
            StInit: begin
                // Also covers any ROM read left in flight by a mid-operation reset.
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (found) begin
                    win_d      = grant;
                    rom_addr_d = grant_addr;
                    rom_rd_d   = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CNT_W'(READ_LAT);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rd_data_d = rom_data;
                    ack_d     = win_q;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            win_q      <= '0;
            ack_q      <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            ready_q    <= ready_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign ack         = ack_q;
    assign rd_data     = rd_data_q;
    assign ready       = ready_q;
    assign rom_rd      = rom_rd_q;
    assign rom_address = rom_addr_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural ROM returning address+1.
module tb_rom_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic            CLK = 1'b0;
    logic            RST_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rd_data;
    logic            ready;
    logic            rom_rd;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;
    int g;
    int a;
    int prev;

    rom_read_arbiter u_dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .req        (req),
        .req_addr   (req_addr),
        .ack        (ack),
        .rd_data    (rd_data),
        .ready      (ready),
        .rom_rd     (rom_rd),
        .rom_address(rom_address),
        .rom_data   (rom_data)
    );

    always #5 CLK = ~CLK;

    // ROM: samples RD at an edge, presents address+1 three edges later.
    logic [2:0]    pv = '0;
    logic [AW-1:0] pa [3];
    always @(posedge CLK) begin
        if (pv[2]) rom_data <= pa[2] + 8'd1;
        pv    <= {pv[1:0], rom_rd};
        pa[2] <= pa[1];
        pa[1] <= pa[0];
        pa[0] <= rom_address;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] addr);
        req_addr[idx*AW +: AW] = addr;
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            tick();
            if (ack != '0) at = edge_n;
        end
    endtask

    task automatic run_read(input int idx, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp_data, output int grant_edge);
        int at;
        int rd_cnt;
        int stray;
        grant_edge = -1;
        at         = -1;
        stray      = 0;
        set_addr(idx, addr);
        req[idx] = 1'b1;
        for (int i = 0; i < 150 && grant_edge < 0; i++) begin
            tick();
            if (ack != '0) stray++;
            if (rom_rd) grant_edge = edge_n;
        end
        check_eq("grant_seen", 32'(grant_edge >= 0), 1);
        check_eq("stray_ack", stray, 0);
        check_eq("rom_address", 32'(rom_address), 32'(addr));
        rd_cnt = 1;
        for (int i = 0; i < 20 && at < 0; i++) begin
            tick();
            if (rom_rd) rd_cnt++;
            if (ack != '0) at = edge_n;
        end
        check_eq("ack_latency", at - grant_edge, 5);
        check_eq("ack_onehot", 32'(ack), 32'(1) << idx);
        check_eq("rd_data", 32'(rd_data), 32'(exp_data));
        check_eq("rd_pulse_len", rd_cnt, 1);
        req[idx] = 1'b0;
        tick();
        check_eq("ack_clear", 32'(ack), 0);
    endtask

    logic [N-1:0]  exp_ack [5];
    logic [DW-1:0] exp_dat [5];

    initial begin
`ifdef ROM_ARB_RR_EN
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h21};
`else
        exp_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_dat = '{8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
`endif

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_ack", 32'(ack), 0);
        check_eq("rst_rd_data", 32'(rd_data), 0);
        check_eq("rst_ready", 32'(ready), 0);
        check_eq("rst_rom_rd", 32'(rom_rd), 0);
        check_eq("rst_rom_address", 32'(rom_address), 0);

        // First read: request raised at cycle 5, granted only after INIT
        RST_n  = 1'b1;
        edge_n = 0;
        repeat (5) tick();
        set_addr(0, 8'h10);
        req[0] = 1'b1;
        while (edge_n < 99) tick();
        check_eq("ready_edge99", 32'(ready), 0);
        tick();
        check_eq("ready_edge100", 32'(ready), 1);
        check_eq("no_rd_in_init", 32'(rom_rd), 0);
        run_read(0, 8'h10, 8'h11, g);
        check_eq("first_grant_edge", g, 101);

        // Wrapping address
        run_read(3, 8'hFF, 8'h00, g);

        // All four held
        set_addr(0, 8'h20);
        set_addr(1, 8'h21);
        set_addr(2, 8'h22);
        set_addr(3, 8'h23);
        req  = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a);
            check_eq($sformatf("multi_ack%0d", k), 32'(ack), 32'(exp_ack[k]));
            check_eq($sformatf("multi_data%0d", k), 32'(rd_data), 32'(exp_dat[k]));
            if (k > 0) check_eq($sformatf("multi_spacing%0d", k), a - prev, 7);
            prev = a;
        end
        req = '0;
        tick();
        tick();

        // req[2] raised in the ack[1] cycle
        set_addr(1, 8'h30);
        set_addr(2, 8'h40);
        req = 4'b0010;
        wait_ack(a);
        check_eq("r1_ack", 32'(ack), 32'b0010);
        check_eq("r1_data", 32'(rd_data), 32'h31);
        req = 4'b0100;
        tick();
        check_eq("idle_gap_rd", 32'(rom_rd), 0);
        tick();
        check_eq("r2_grant", 32'(rom_rd), 1);
        check_eq("r2_address", 32'(rom_address), 32'h40);
        wait_ack(a);
        check_eq("r2_ack", 32'(ack), 32'b0100);
        check_eq("r2_data", 32'(rd_data), 32'h41);
        req = '0;
        tick();

        // Reset pulsed while waiting on the ROM
        set_addr(0, 8'h5A);
        req[0] = 1'b1;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            tick();
            if (rom_rd) g = edge_n;
        end
        check_eq("abort_grant_seen", 32'(g >= 0), 1);
        tick();
        tick();
        #2;
        RST_n = 1'b0;
        #1;
        check_eq("abort_ready", 32'(ready), 0);
        check_eq("abort_ack", 32'(ack), 0);
        check_eq("abort_rom_rd", 32'(rom_rd), 0);
        check_eq("abort_rom_address", 32'(rom_address), 0);
        check_eq("abort_rd_data", 32'(rd_data), 0);
        @(posedge CLK);
        #1;
        RST_n  = 1'b1;
        edge_n = 0;
        run_read(0, 8'h5A, 8'h5B, g);
        check_eq("post_reset_grant_edge", g, 101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares one fixed-latency read-only ROM among `N_REQ` requesters. The block waits out the ROM's power-up period, then arbitrates among pending read requests. For each winner it issues a single-cycle read strobe, waits the ROM's fixed data latency, captures the data and returns it with a one-cycle acknowledge. It sits between the test/control masters and the ROM, and is the only driver of the ROM's `RD` and `address` inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `ADDR_W`, 8: ROM address width
- `DATA_W`, 8: ROM data width
- `READ_LAT`, 3: ROM clocks from sampled `RD` to data update
- `INIT_CYCLES`, 100: clocks after reset before the first grant; must be ≥ `READ_LAT`+1
- `CLK`  in  1  clock, all logic on rising edge
- `RST_n`  in  1  asynchronous active-low reset
- `req`  in  N_REQ  per-requester read request, level, held until `ack`
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; slice i belongs to `req[i]`, stable while `req[i]`=1
- `ack`  out  N_REQ  one-hot, one-cycle pulse: read complete for requester i
- `rd_data`  out  DATA_W  captured ROM data, valid while any `ack` bit is 1
- `ready`  out  1  0 during reset and INIT, 1 afterwards
- `rom_rd`  out  1  ROM `RD`, registered, high for exactly one cycle per read
- `rom_address`  out  ADDR_W  ROM `address`, registered, held from issue until the next issue
- `rom_data`  in  DATA_W  ROM `data`

## Operation
- States: INIT, IDLE, ISSUE, WAIT, DONE.
- Reset values: state=INIT, `ack`=0, `rd_data`=0, `ready`=0, `rom_rd`=0, `rom_address`=0, wait counter=0, round-robin pointer=0.
- INIT:
  - Counts `INIT_CYCLES` rising edges after `RST_n` deasserts, then moves to IDLE and sets `ready`=1.
  - `req` is ignored throughout.
- IDLE:
  - If any `req` bit is 1 at an edge, latch the winner index, load `rom_address` from the winner's slice, set `rom_rd`=1, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle): `rom_rd`=1. At the next edge, clear `rom_rd`, load counter=`READ_LAT`, and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter reads 0, capture `rom_data` into `rd_data`, set `ack[winner]`=1, and go to DONE.
- DONE (one cycle): `ack` high. At the next edge, clear `ack` and go to IDLE. `rd_data` holds its value until the next capture.
- Only one read is outstanding at a time. `rom_rd` is never reasserted before the ROM's previous read completes.
- Requester rule:
  - The served requester deasserts `req` no later than the edge ending its `ack` cycle.
  - A `req` still high at the next IDLE edge is a new request.
- Request withdrawal before `ack` is illegal. A read already issued completes and is acknowledged regardless.
- Reset mid-operation forces all outputs to their reset values immediately. The block re-enters INIT, and the full `INIT_CYCLES` wait covers any ROM read still in flight.
- Address arithmetic: none. `rom_address` is passed through unmodified.

## Timing
- Ts = the IDLE edge that grants.
- `rom_rd` is high during cycle Ts..Ts+1 and is sampled by the ROM at edge T0 = Ts+1.
- The ROM updates its data at T0+`READ_LAT`.
- The arbiter captures at T0+`READ_LAT`+1 = Ts+5 (default). `ack` is high for cycle Ts+5..Ts+6.
- Request-to-ack latency: `READ_LAT`+2 edges.
- Back-to-back service: next grant at edge Ts+7, so reads are spaced 7 cycles apart at default.
- First possible grant: edge `INIT_CYCLES`+1 after reset release.

## Configuration
- `ROM_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer advances to winner+1 (mod `N_REQ`) on each grant.
  - The search starts at the pointer. With continuous requests, no requester waits more than `N_REQ`-1 grants.
- `ROM_ARB_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is not compiled.

## Structure
- Package `rom_arb_pkg` contains:
  - the state enum (INIT, IDLE, ISSUE, WAIT, DONE);
  - default constants: `READ_LAT`=3, `INIT_CYCLES`=100.
- Sub-module `rom_arb_pick`: combinational picker taking `req` and the start pointer and returning a one-hot winner plus a `found` flag. It is instantiated once. The pointer input is tied to 0 when `ROM_ARB_RR_EN` is undefined.

## Test plan
- Reset, then `req[0]`=1 with address 8'h10 at cycle 5 → no `rom_rd` before edge 101. `ack[0]` arrives 5 edges after the grant with `rd_data`=8'h11.
- Single read of address 8'hFF → `rd_data`=8'h00 (ROM wraps). `rom_rd` is high for exactly one cycle.
- `req[3:0]`=4'b1111 held, addresses 8'h20..8'h23:
  - RR build: `ack` order 0,1,2,3,0, data 8'h21,8'h22,8'h23,8'h24,8'h21, grants 7 cycles apart.
  - Fixed build: `ack[0]` every time.
- `RST_n` pulsed low during WAIT → `ack`/`rom_rd` are 0 immediately, `ready`=0, no `ack` for the aborted read. A new read after INIT returns correct data.
- `req[2]` asserted in the same cycle `ack[1]` fires (RR, pointer at 2) → `req[2]` is granted at the next IDLE edge and `rom_address` changes to its address.
